// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with 2-entry skid buffer and flush-to-NOP bubble insertion.
// Latency: 1 cycle push-to-valid_o; sustains 1 transfer/cycle while ready_i stays high.
// Backpressure: ready_o is decoded from the state register only, so it never depends combinationally on ready_i.
// Optional build macro PIPE_STAT_EN adds stall_cnt_o, a saturating count of cycles stalled by downstream.
module pipe_stage_reg #(
    parameter int unsigned     DW      = 64,
    parameter logic [DW-1:0]   NOP_VAL = {DW{1'b0}},
    parameter int unsigned     CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DW-1:0]     data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DW-1:0]     data_o,
    input  logic              flush_i
`ifdef PIPE_STAT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    // Catch out-of-range configurations at elaboration time.
    if (DW < 1 || DW > 512 || CNT_W < 1) begin : g_bad_param
        $error("pipe_stage_reg: DW must be 1..512 and CNT_W at least 1");
    end

    // 2'b11 is unused; it decodes as "no valid, no ready" and falls back to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t          state_q, state_n;
    logic [DW-1:0]   m_q, m_n;      // main entry, always the older one, drives data_o
    logic [DW-1:0]   s_q, s_n;      // skid entry, only meaningful in FULL
    logic            push, pop;

    assign data_o = m_q;

    // Output decode from state, handshake qualification and next-state/datapath selection.
    always_comb begin
        state_n = state_q;
        m_n     = m_q;
        s_n     = s_q;
        valid_o = 1'b0;
        ready_o = 1'b0;

        case (state_q)
            EMPTY:   begin valid_o = 1'b0; ready_o = 1'b1; end
            ONE:     begin valid_o = 1'b1; ready_o = 1'b1; end
            FULL:    begin valid_o = 1'b1; ready_o = 1'b0; end
            default: begin valid_o = 1'b0; ready_o = 1'b0; end
        endcase

        push = valid_i & ready_o;
        pop  = valid_o & ready_i;

        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_n = ONE;
                    m_n     = data_i;
                end
            end
            ONE: begin
                if (push && pop) begin
                    m_n = data_i;
                end else if (push) begin
                    state_n = FULL;
                    s_n     = data_i;
                end else if (pop) begin
                    state_n = EMPTY;
                    m_n     = NOP_VAL;
                end
            end
            FULL: begin
                if (pop) begin
                    state_n = ONE;
                    m_n     = s_q;
                end
            end
            default: begin
                state_n = EMPTY;
                m_n     = NOP_VAL;
            end
        endcase

        // Flush drops both held entries and any incoming payload; a same-cycle pop was
        // already sampled downstream, so nothing else needs undoing.
        if (flush_i) begin
            state_n = EMPTY;
            m_n     = NOP_VAL;
        end
    end

    // State and payload registers; reset wins over flush and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            m_q     <= NOP_VAL;
            s_q     <= '0;
        end else begin
            state_q <= state_n;
            m_q     <= m_n;
            s_q     <= s_n;
        end
    end

`ifdef PIPE_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    assign stall_cnt_o = stall_cnt_q;

    // Count cycles where a valid payload is held back by downstream; saturates, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (valid_o && !ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int unsigned    DW      = 64;
    localparam logic [DW-1:0]  NOP     = 64'h13;
`ifdef PIPE_STAT_EN
    localparam int unsigned    CNT_W   = 2;
`else
    localparam int unsigned    CNT_W   = 16;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [DW-1:0]   data_i = '0;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [DW-1:0]   data_o;
    logic            flush_i = 1'b0;
`ifdef PIPE_STAT_EN
    logic [CNT_W-1:0] stall_cnt_o;
`endif

    int              total = 0;
    int              bad   = 0;
    logic [DW-1:0]   exp_q[$];

    pipe_stage_reg #(
        .DW      (DW),
        .NOP_VAL (NOP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .flush_i     (flush_i)
`ifdef PIPE_STAT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    // Accepted payloads enter the scoreboard; flush/reset discard whatever was still pending.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic f, input logic rs);
        logic acc;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        rst     = rs;
        @(negedge clk);
        acc = v && (ready_o === 1'b1) && !f && !rs;
        @(posedge clk);
        if (f || rs) exp_q.delete();
        if (acc) exp_q.push_back(d);
        #1;
    endtask

    task automatic chk_empty(input string name);
        chk({name, "_valid"}, {63'd0, valid_o}, 64'd0);
        chk({name, "_ready"}, {63'd0, ready_o}, 64'd1);
        chk({name, "_data"},  data_o, NOP);
    endtask

    initial begin
        fork
            // Monitor: every downstream transfer must match the oldest outstanding payload.
            begin
                forever begin
                    @(negedge clk);
                    if (rst === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_pop actual=%h required=none", data_o);
                        end else begin
                            chk("pop_data", data_o, exp_q.pop_front());
                        end
                    end
                end
            end
        join_none

        // Reset then idle
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk_empty("reset");
        step(0, 0, 0, 0, 0);
        chk_empty("idle");

        // Streaming at full throughput
        step(1, 64'h1, 1, 0, 0);
        chk("stream1_data", data_o, 64'h1);
        chk("stream1_valid", {63'd0, valid_o}, 64'd1);
        step(1, 64'h2, 1, 0, 0);
        chk("stream2_data", data_o, 64'h2);
        chk("stream2_ready", {63'd0, ready_o}, 64'd1);
        step(1, 64'h3, 1, 0, 0);
        chk("stream3_data", data_o, 64'h3);
        chk("stream3_ready", {63'd0, ready_o}, 64'd1);
        step(0, 0, 1, 0, 0);
        chk_empty("stream_end");

        // Back-pressure into the skid register, then drain in order
        step(1, 64'hA, 0, 0, 0);
        step(1, 64'hB, 0, 0, 0);
        chk("bp_full_ready", {63'd0, ready_o}, 64'd0);
        chk("bp_full_data", data_o, 64'hA);
        step(1, 64'hE, 0, 0, 0);
        chk("bp_hold_data", data_o, 64'hA);
        chk("bp_hold_valid", {63'd0, valid_o}, 64'd1);
        step(0, 0, 1, 0, 0);
        chk("bp_second_data", data_o, 64'hB);
        step(0, 0, 1, 0, 0);
        chk_empty("bp_drained");

        // Flush colliding with push and pop while FULL
        step(1, 64'hA, 0, 0, 0);
        step(1, 64'hB, 0, 0, 0);
        step(1, 64'hC, 1, 1, 0);
        chk_empty("flush");
        step(0, 0, 1, 0, 0);
        chk_empty("flush_after");

        // Reset mid-operation with flush and valid also asserted
        step(1, 64'hA, 0, 0, 0);
        step(1, 64'hB, 0, 0, 0);
        step(1, 64'h9, 0, 1, 1);
        chk_empty("midreset");
        step(1, 64'h5, 1, 0, 0);
        chk("post_reset_data", data_o, 64'h5);
        chk("post_reset_valid", {63'd0, valid_o}, 64'd1);
        step(1, 64'h6, 0, 0, 0);
        step(1, 64'h7, 0, 0, 0);
        chk("post_reset_full", {63'd0, ready_o}, 64'd0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_empty("post_reset_drain");

`ifdef PIPE_STAT_EN
        // Saturating stall counter with CNT_W=2
        step(0, 0, 0, 0, 1);
        step(1, 64'h7, 0, 0, 0);
        chk("stall_start", {{(DW-CNT_W){1'b0}}, stall_cnt_o}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("stall_cnt_%0d", i), {{(DW-CNT_W){1'b0}}, stall_cnt_o},
                (i < 3) ? 64'(i + 1) : 64'd3);
        end
        step(0, 0, 1, 1, 0);
        chk("stall_after_flush", {{(DW-CNT_W){1'b0}}, stall_cnt_o}, 64'd3);
        chk_empty("stall_flush");
`endif

        // Bounded drain, then every accepted payload must have been delivered
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(0, 0, 1, 0, 0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
